// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: transmitting end of the GPIO pad config chain.
// Holds one pad word per IO, shifts them all out, then strobes load.
module gpio_serial_loader #(
    parameter int NUM_IO        = 19,
    parameter int PAD_CTRL_BITS = 10,
    parameter int CLK_DIV       = 1
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_IO*PAD_CTRL_BITS-1:0]   gpio_defaults,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_IO)-1:0]         cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0]          cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0]          cfg_rdata,
    input  logic                              xfer_start,
    output logic                              busy,
    output logic                              done,
    output logic                              serial_clock,
    output logic                              serial_load,
    output logic                              serial_resetn,
    output logic                              serial_data_out
);

    localparam int N  = NUM_IO * PAD_CTRL_BITS;
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLK_LO,
        CLK_HI,
        LOAD_SETUP,
        LOAD_HI,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   div_q;
    logic [DW-1:0]   div_d;
    logic [BW-1:0]   bit_q;
    logic [BW-1:0]   bit_d;
    logic [N-1:0]    cfg_q;

    logic            phase_end;
    logic            addr_ok;
    logic            cfg_wr;
    logic [IW-1:0]   word_lsb;
    logic [IW-1:0]   next_idx;

    logic            sdo_d;
    logic            busy_d;
    logic            done_d;
    logic            sclk_d;
    logic            sload_d;

    // The whole store is one flat vector laid out exactly like gpio_defaults,
    // so the bit sent k-th is simply flat bit N-1-k.
    assign addr_ok   = 32'(cfg_addr) < NUM_IO;
    assign word_lsb  = IW'(int'(cfg_addr) * PAD_CTRL_BITS);
    assign next_idx  = IW'(N - 1 - int'(bit_q));
    assign cfg_wr    = cfg_we & ~busy & addr_ok;
    assign phase_end = (div_q == DIV_LAST);

    assign cfg_rdata = addr_ok ? cfg_q[word_lsb +: PAD_CTRL_BITS] : '0;

    // Config store: defaults on reset, register writes only while idle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cfg_q <= gpio_defaults;
        end else if (cfg_wr) begin
            cfg_q[word_lsb +: PAD_CTRL_BITS] <= cfg_wdata;
        end
    end

    // Transfer sequencer: next state, counters and next output values.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sdo_d   = serial_data_out;

        unique case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    state_d = CLK_LO;
                    div_d   = '0;
                    bit_d   = '0;
                    sdo_d   = cfg_q[N-1];
                end
            end
            CLK_LO: begin
                if (phase_end) begin
                    state_d = CLK_HI;
                    div_d   = '0;
                    if (bit_q != BIT_LAST) begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            CLK_HI: begin
                if (phase_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LOAD_SETUP;
                    end else begin
                        state_d = CLK_LO;
                        sdo_d   = cfg_q[next_idx];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            LOAD_SETUP: begin
                if (phase_end) begin
                    state_d = LOAD_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            LOAD_HI: begin
                if (phase_end) begin
                    state_d = DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = state_d inside {CLK_LO, CLK_HI, LOAD_SETUP, LOAD_HI};
        done_d  = (state_d == DONE);
        sclk_d  = (state_d == CLK_HI);
        sload_d = (state_d == LOAD_HI);
    end

    // State, counters and registered chain outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= IDLE;
            div_q           <= '0;
            bit_q           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_load     <= 1'b0;
            serial_data_out <= 1'b0;
            serial_resetn   <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            bit_q           <= bit_d;
            busy            <= busy_d;
            done            <= done_d;
            serial_clock    <= sclk_d;
            serial_load     <= sload_d;
            serial_data_out <= sdo_d;
            serial_resetn   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: two loaders (divide 1 and 3) on shared stimulus,
// a cycle model of the serial protocol, and a two-block chain receiver.
module tb_gpio_serial_loader;

    localparam int NIO = 2;
    localparam int PB  = 10;
    localparam int N   = NIO * PB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  defaults = 20'h0A5C3;
    logic          we = 1'b0;
    logic [0:0]    addr = '0;
    logic [PB-1:0] wdata = '0;
    logic          start = 1'b0;

    logic [PB-1:0] rdata [2];
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    sclk;
    logic [1:0]    sload;
    logic [1:0]    srstn;
    logic [1:0]    sdo;

    always #5 clk = ~clk;

    gpio_serial_loader #(.NUM_IO(NIO), .PAD_CTRL_BITS(PB), .CLK_DIV(1)) u_div1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(defaults),
        .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata), .cfg_rdata(rdata[0]),
        .xfer_start(start), .busy(busy[0]), .done(done[0]),
        .serial_clock(sclk[0]), .serial_load(sload[0]),
        .serial_resetn(srstn[0]), .serial_data_out(sdo[0])
    );

    gpio_serial_loader #(.NUM_IO(NIO), .PAD_CTRL_BITS(PB), .CLK_DIV(3)) u_div3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(defaults),
        .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata), .cfg_rdata(rdata[1]),
        .xfer_start(start), .busy(busy[1]), .done(done[1]),
        .serial_clock(sclk[1]), .serial_load(sload[1]),
        .serial_resetn(srstn[1]), .serial_data_out(sdo[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PB-1:0] mst   [2][NIO];
    logic [PB-1:0] snapw [2][NIO];
    bit            act   [2];
    int            cnt   [2];
    logic e_busy [2];
    logic e_done [2];
    logic e_sclk [2];
    logic e_load [2];
    logic e_sdo  [2];
    logic e_rstn [2];
    bit   mvalid = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            int tot;
            int b;
            bit was_done;
            bit was_busy;
            d   = (i == 0) ? 1 : 3;
            tot = (2 * N + 2) * d;
            if (rst) begin
                act[i] = 0;
                cnt[i] = 0;
                for (int k = 0; k < NIO; k++) mst[i][k] = defaults[k*PB +: PB];
                e_busy[i] = 0; e_done[i] = 0; e_sclk[i] = 0;
                e_load[i] = 0; e_sdo[i]  = 0; e_rstn[i] = 0;
            end else begin
                e_rstn[i] = 1;
                was_done  = e_done[i];
                was_busy  = e_busy[i];
                e_done[i] = 0;
                if (act[i]) begin
                    cnt[i]++;
                    if (cnt[i] == tot) begin
                        act[i]    = 0;
                        e_done[i] = 1;
                    end
                end else if (!was_done && start) begin
                    act[i] = 1;
                    cnt[i] = 0;
                    for (int k = 0; k < NIO; k++) snapw[i][k] = mst[i][k];
                end
                if (we && !was_busy && int'(addr) < NIO) mst[i][addr] = wdata;
                e_busy[i] = act[i];
                e_sclk[i] = 0;
                e_load[i] = 0;
                if (act[i]) begin
                    if (cnt[i] < 2 * N * d) begin
                        e_sclk[i] = ((cnt[i] / d) % 2) == 1;
                        b = cnt[i] / (2 * d);
                        e_sdo[i] = snapw[i][NIO - 1 - b / PB][PB - 1 - b % PB];
                    end else if (cnt[i] >= (2 * N + 1) * d) begin
                        e_load[i] = 1;
                    end
                end
            end
        end
        mvalid = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                int exp_rd;
                chk($sformatf("outs_u%0d", i),
                    int'({busy[i], done[i], sclk[i], sload[i], sdo[i], srstn[i]}),
                    int'({e_busy[i], e_done[i], e_sclk[i], e_load[i], e_sdo[i], e_rstn[i]}));
                exp_rd = (int'(addr) < NIO) ? int'(mst[i][addr]) : 0;
                chk($sformatf("rdata_u%0d", i), int'(rdata[i]), exp_rd);
            end
        end
    end

    // ---------------- transfer monitor + chain receiver ----------------
    int bcnt [2];
    int rises [2];
    int lcnt [2];
    int hmin [2];
    int hmax [2];
    int hrun [2];
    int hichg [2];
    int ndone [2];
    int last_load [2];
    int done_cyc [2];
    logic [N-1:0]  chain [2];
    logic [PB-1:0] blk0 [2];
    logic [PB-1:0] blk1 [2];
    logic pb [2];
    logic ps [2];
    logic pl [2];
    logic pd [2];
    int   cyc = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            pb[i] = 0; ps[i] = 0; pl[i] = 0; pd[i] = 0;
            bcnt[i] = 0; rises[i] = 0; lcnt[i] = 0; hmin[i] = 0; hmax[i] = 0;
            hrun[i] = 0; hichg[i] = 0; ndone[i] = 0; last_load[i] = 0;
            done_cyc[i] = 0; chain[i] = '0; blk0[i] = '0; blk1[i] = '0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (busy[i] === 1'b1 && pb[i] !== 1'b1) begin
                bcnt[i] = 0; rises[i] = 0; lcnt[i] = 0; hmin[i] = 1000;
                hmax[i] = 0; hrun[i] = 0; hichg[i] = 0; ndone[i] = 0;
                chain[i] = '0;
            end
            if (busy[i] === 1'b1) bcnt[i]++;
            if (sclk[i] === 1'b1) begin
                if (ps[i] !== 1'b1) begin
                    rises[i]++;
                    chain[i] = {chain[i][N-2:0], sdo[i]};
                end
                hrun[i]++;
                if (sdo[i] !== pd[i]) hichg[i]++;
            end else if (ps[i] === 1'b1) begin
                if (hrun[i] < hmin[i]) hmin[i] = hrun[i];
                if (hrun[i] > hmax[i]) hmax[i] = hrun[i];
                hrun[i] = 0;
            end
            if (sload[i] === 1'b1) begin
                lcnt[i]++;
                last_load[i] = cyc;
                if (pl[i] !== 1'b1) begin
                    blk0[i] = chain[i][PB-1:0];
                    blk1[i] = chain[i][N-1:PB];
                end
            end
            if (done[i] === 1'b1) begin
                ndone[i]++;
                done_cyc[i] = cyc;
            end
            pb[i] = busy[i];
            ps[i] = sclk[i];
            pl[i] = sload[i];
            pd[i] = sdo[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [0:0] a, input logic [PB-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (done[1] === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_done timeout after %0d cycles", budget);
        end
        step();
    endtask

    initial begin
        bit hit;
        repeat (3) step();
        chk("rstn_in_reset", int'(srstn), 0);
        rst = 1'b0;
        step();
        chk("rstn_after_release", int'(srstn), 3);
        addr = 1'b0; #1;
        chk("default_io0", int'(rdata[0]), 10'h1C3);
        addr = 1'b1; #1;
        chk("default_io1", int'(rdata[1]), 10'h029);

        write(1'b0, 10'h3FF);
        write(1'b1, 10'h001);
        pulse_start();
        wait_done(300);
        chk("busy_len_div1", bcnt[0], 42);
        chk("busy_len_div3", bcnt[1], 126);
        chk("rises_div1", rises[0], 20);
        chk("rises_div3", rises[1], 20);
        chk("stream_div1", int'(chain[0]), 20'h007FF);
        chk("stream_div3", int'(chain[1]), 20'h007FF);
        chk("load_len_div1", lcnt[0], 1);
        chk("load_len_div3", lcnt[1], 3);
        chk("done_after_load", done_cyc[0], last_load[0] + 1);
        chk("done_count", ndone[0], 1);
        chk("blk0_div1", int'(blk0[0]), 10'h3FF);
        chk("blk1_div1", int'(blk1[0]), 10'h001);
        chk("blk0_div3", int'(blk0[1]), 10'h3FF);
        chk("blk1_div3", int'(blk1[1]), 10'h001);
        chk("hi_min_div3", hmin[1], 3);
        chk("hi_max_div3", hmax[1], 3);
        chk("sdo_change_hi_div3", hichg[1], 0);

        pulse_start();
        repeat (5) step();
        write(1'b0, 10'h155);
        wait_done(300);
        chk("stream_busywr_div1", int'(chain[0]), 20'h007FF);
        chk("stream_busywr_div3", int'(chain[1]), 20'h007FF);
        addr = 1'b0; #1;
        chk("busy_write_dropped", int'(rdata[0]), 10'h3FF);
        write(1'b0, 10'h155);
        #1;
        chk("idle_write_div1", int'(rdata[0]), 10'h155);
        chk("idle_write_div3", int'(rdata[1]), 10'h155);

        pulse_start();
        hit = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rises[0] >= 7) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL bit7 wait timeout rises=%0d", rises[0]);
        end
        rst = 1'b1;
        step();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rstn", int'(srstn), 0);
        rst = 1'b0;
        repeat (5) step();
        chk("midrst_no_done_div1", ndone[0], 0);
        chk("midrst_no_done_div3", ndone[1], 0);
        addr = 1'b0; #1;
        chk("midrst_io0", int'(rdata[0]), 10'h1C3);
        addr = 1'b1; #1;
        chk("midrst_io1", int'(rdata[0]), 10'h029);
        pulse_start();
        wait_done(300);
        chk("post_rst_stream_div1", int'(chain[0]), 20'h0A5C3);
        chk("post_rst_stream_div3", int'(chain[1]), 20'h0A5C3);
        chk("post_rst_done", ndone[0], 1);
        chk("post_rst_busy_len", bcnt[1], 126);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
